// File: rtl/gb_mem_arbiter.sv
// gb_mem_arbiter: shares the single memory port among OAM DMA, PPU and CPU, and runs the FF46 OAM DMA copy.
// Latency: a granted read/write acks one cycle after its grant; blocked or internal (FF46) CPU accesses also ack next cycle.
// Backpressure: requesters hold rd/wr until their ack; DMA RD/WR slots beat PPU beats CPU, and the loser keeps waiting.
// Ports: clk/rst; cpu_* CPU bus (rd/wr held until cpu_ack); ppu_* PPU fetch port (ppu_rd held until ppu_ack);
//        ppu_mode/lcd_en drive the CPU lockouts; mem_* external memory (mem_rdata valid one cycle after mem_rd);
//        dma_active is high while an OAM DMA copy is in progress.
module gb_mem_arbiter #(
    parameter int DMA_SPACING = 4,
    parameter int DMA_LEN     = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic [1:0]  ppu_mode,
    input  logic        lcd_en,
    input  logic        ppu_rd,
    input  logic [15:0] ppu_addr,
    output logic [7:0]  ppu_rdata,
    output logic        ppu_ack,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    typedef enum logic [1:0] {DMA_IDLE, DMA_RD, DMA_WR, DMA_GAP} dma_state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_PPU, TAG_CPU, TAG_DMA} tag_t;

    localparam int            CW       = $clog2(DMA_SPACING + 1);
    localparam logic [7:0]    LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(DMA_SPACING - 1);

    dma_state_t    state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    src_hi_q, src_hi_d;
    logic [CW-1:0] cnt_q, cnt_d;     // clocks elapsed since the current byte's RD
    tag_t          tag_q, tag_d;     // owner of the read whose data is on mem_rdata now
    logic [7:0]    cpu_rdata_q, ppu_rdata_q;
    logic          cpu_ack_q, ppu_ack_q;

    logic dma_slot, ppu_req, cpu_req;
    logic in_vram, in_oam, cpu_blocked, ff46_wr;
    logic cpu_internal, ppu_grant, cpu_grant, cpu_accept, dma_start;

    assign dma_active = (state_q != DMA_IDLE);
    assign dma_slot   = (state_q == DMA_RD) || (state_q == DMA_WR);

    // A request seen in its own ack cycle is the old one still held; ignore it.
    assign ppu_req = ppu_rd & ~ppu_ack_q & ~rst;
    assign cpu_req = (cpu_rd | cpu_wr) & ~cpu_ack_q & ~rst;

    assign in_vram = (cpu_addr[15:13] == 3'b100);
    assign in_oam  = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] < 8'hA0);

    // OAM is owned by the PPU in SCAN/DRAW and by DMA while it runs; VRAM only in DRAW.
    assign cpu_blocked = (in_oam & ((lcd_en & ppu_mode[1]) | dma_active))
                       | (in_vram & lcd_en & (ppu_mode == 2'd3));
    assign ff46_wr     = cpu_wr & (cpu_addr == 16'hFF46);

    // Blocked accesses and the FF46 write never touch the port, so they complete even during DMA slots.
    assign cpu_internal = cpu_req & (ff46_wr | cpu_blocked);
    assign ppu_grant    = ppu_req & ~dma_slot;
    assign cpu_grant    = cpu_req & ~cpu_internal & ~dma_slot & ~ppu_req;
    assign cpu_accept   = cpu_internal | cpu_grant;
    assign dma_start    = cpu_req & ff46_wr;

    // DMA sequencing: RD, WR, then GAP until DMA_SPACING clocks have passed since RD.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_hi_d = src_hi_q;
        cnt_d    = cnt_q;
        case (state_q)
            DMA_IDLE: begin
                cnt_d = '0;
            end
            DMA_RD: begin
                state_d = DMA_WR;
                cnt_d   = cnt_q + CW'(1);
            end
            DMA_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DMA_IDLE;
                    cnt_d   = '0;
                end else if (DMA_SPACING <= 2) begin
                    state_d = DMA_RD;
                    idx_d   = idx_q + 8'd1;
                    cnt_d   = '0;
                end else begin
                    state_d = DMA_GAP;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DMA_GAP: begin
                if (cnt_q == GAP_END) begin
                    state_d = DMA_RD;
                    idx_d   = idx_q + 8'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = DMA_IDLE;
                cnt_d   = '0;
            end
        endcase
        // A new FF46 write overrides whatever the copy was doing; a pending WR is simply dropped.
        if (dma_start) begin
            state_d  = DMA_RD;
            idx_d    = '0;
            cnt_d    = '0;
            src_hi_d = cpu_wdata;
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (state_q == DMA_RD) begin
            tag_d = TAG_DMA;
        end else if (ppu_grant) begin
            tag_d = TAG_PPU;
        end else if (cpu_grant && !cpu_wr) begin
            tag_d = TAG_CPU;
        end
    end

    // Port mux; DMA WR forwards the byte returned by the previous cycle's DMA RD straight through.
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        if (state_q == DMA_RD) begin
            mem_rd   = 1'b1;
            mem_addr = {src_hi_q, idx_q};
        end else if (state_q == DMA_WR) begin
            mem_wr    = 1'b1;
            mem_addr  = {8'hFE, idx_q};
            mem_wdata = mem_rdata;
        end else if (ppu_grant) begin
            mem_rd   = 1'b1;
            mem_addr = ppu_addr;
        end else if (cpu_grant) begin
            mem_rd    = ~cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DMA_IDLE;
            idx_q       <= '0;
            src_hi_q    <= '0;
            cnt_q       <= '0;
            tag_q       <= TAG_NONE;
            cpu_ack_q   <= 1'b0;
            ppu_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            ppu_rdata_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            src_hi_q  <= src_hi_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            cpu_ack_q <= cpu_accept;
            ppu_ack_q <= ppu_grant;
            if (cpu_internal && cpu_blocked && !cpu_wr) begin
                cpu_rdata_q <= 8'hFF;
            end else if (tag_q == TAG_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (tag_q == TAG_PPU) begin
                ppu_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data rides through combinationally in the ack cycle, then stays held.
    assign cpu_rdata = (tag_q == TAG_CPU) ? mem_rdata : cpu_rdata_q;
    assign ppu_rdata = (tag_q == TAG_PPU) ? mem_rdata : ppu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ppu_ack   = ppu_ack_q;

endmodule

// File: tb/tb_gb_mem_arbiter.sv
// tb_gb_mem_arbiter: directed bench for gb_mem_arbiter with a cycle-level behavioural model and a memory model.
// Inputs change on the falling edge; outputs are sampled 2 time units after it, ahead of the rising edge.
module tb_gb_mem_arbiter;

    localparam int S    = 4;
    localparam int L    = 160;
    localparam int LAST = (L - 1) * S + 1;   // offset of the final WR from the first RD

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [1:0]  ppu_mode;
    logic        lcd_en;
    logic        ppu_rd;
    logic [15:0] ppu_addr;
    logic [7:0]  ppu_rdata;
    logic        ppu_ack;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        dma_active;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_arr [0:65535];

    gb_mem_arbiter #(.DMA_SPACING(S), .DMA_LEN(L)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ppu_mode(ppu_mode), .lcd_en(lcd_en),
        .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata), .ppu_ack(ppu_ack),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dma_active(dma_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_arr[mem_addr];
        if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[15:8] ^ a[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int         cyc = 0;
    bit         m_dma_on = 0;
    int         m_base = 0;
    logic [7:0] m_src = 8'h00;
    bit         m_cack = 0, m_pack = 0, m_crd = 0;
    logic [7:0] m_crdata = 8'h00, m_prdata = 8'h00;

    initial begin : compare
        bit e_act, e_rd, e_wr, busy, p_want, c_want, ff46w, blk, c_int, c_mem, in_vr, in_oa;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        int off, k, ph;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                check("reset_ctrl", {27'd0, dma_active, cpu_ack, ppu_ack, mem_rd, mem_wr}, 32'd0);
                m_dma_on = 0; m_cack = 0; m_pack = 0; m_crd = 0;
            end else begin
                e_act = 0; e_rd = 0; e_wr = 0; busy = 0; e_addr = '0; e_wd = '0;
                if (m_dma_on) begin
                    off = cyc - m_base;
                    if (off >= 0 && off <= LAST) begin
                        e_act = 1;
                        k  = off / S;
                        ph = off % S;
                        if (ph == 0) begin
                            e_rd = 1; busy = 1; e_addr = {m_src, 8'(k)};
                        end else if (ph == 1) begin
                            e_wr = 1; busy = 1; e_addr = 16'hFE00 + 16'(k);
                            e_wd = mem_arr[{m_src, 8'(k)}];
                        end
                    end
                end
                p_want = ppu_rd && !m_pack;
                c_want = (cpu_rd || cpu_wr) && !m_cack;
                ff46w  = cpu_wr && (cpu_addr == 16'hFF46);
                in_vr  = (cpu_addr >= 16'h8000) && (cpu_addr <= 16'h9FFF);
                in_oa  = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
                blk    = (in_oa && ((lcd_en && ppu_mode >= 2) || e_act))
                       || (in_vr && lcd_en && ppu_mode == 3);
                c_int  = c_want && (ff46w || blk);
                if (p_want && !busy) begin
                    e_rd = 1; e_addr = ppu_addr; busy = 1;
                end
                c_mem = c_want && !c_int && !busy;
                if (c_mem) begin
                    e_rd = !cpu_wr; e_wr = cpu_wr; e_addr = cpu_addr; e_wd = cpu_wdata;
                end

                check("ctrl{act,cack,pack,rd,wr}", {27'd0, dma_active, cpu_ack, ppu_ack, mem_rd, mem_wr},
                      {27'd0, e_act, m_cack, m_pack, e_rd, e_wr});
                if (e_rd || e_wr) check("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
                if (e_wr) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e_wd});
                if (m_cack && m_crd) check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, m_crdata});
                if (m_pack) check("ppu_rdata", {24'd0, ppu_rdata}, {24'd0, m_prdata});

                // effects of this cycle, visible from the next one
                m_pack   = p_want && !(e_act && (ph == 0 || ph == 1));
                m_prdata = mem_arr[ppu_addr];
                m_cack   = c_int || c_mem;
                m_crd    = !cpu_wr;
                m_crdata = c_int ? 8'hFF : mem_arr[cpu_addr];
                if (c_want && ff46w) begin
                    m_dma_on = 1; m_base = cyc + 1; m_src = cpu_wdata;
                end else if (m_dma_on && (cyc - m_base) >= LAST) begin
                    m_dma_on = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cpu_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                              output logic [7:0] rdata, output int lat);
        bit got;
        got = 0; lat = -1; rdata = 8'h00;
        @(negedge clk);
        cpu_addr = a; cpu_wdata = d; cpu_wr = wr; cpu_rd = !wr;
        for (int i = 0; i < 64 && !got; i++) begin
            #2;
            if (cpu_ack) begin
                got = 1; lat = i; rdata = cpu_rdata;
            end else begin
                @(negedge clk);
            end
        end
        check("cpu_ack_seen", {31'd0, got}, 32'd1);
        @(negedge clk);
        cpu_rd = 0; cpu_wr = 0;
    endtask

    task automatic wait_dma_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 1200 && !done; i++) begin
            @(negedge clk);
            #2;
            if (!dma_active) done = 1;
        end
        check(name, {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic oam_compare(input string name, input logic [7:0] src);
        int bad;
        bad = 0;
        for (int k = 0; k < L; k++)
            if (mem_arr[16'hFE00 + 16'(k)] !== pat({src, 8'(k)})) bad++;
        check(name, bad, 0);
    endtask

    initial begin : stim
        logic [7:0] rd;
        int lat;
        bit seen;
        for (int a = 0; a < 65536; a++) mem_arr[a] = pat(16'(a));
        mem_arr[16'h8010] = 8'h5A;
        rst = 1'b1;
        cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = '0;
        ppu_mode = 2'd0; lcd_en = 0; ppu_rd = 0; ppu_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("reset_cpu_rdata", {24'd0, cpu_rdata}, 32'h00);
        check("reset_ppu_rdata", {24'd0, ppu_rdata}, 32'h00);
        check("reset_outs", {28'd0, dma_active, mem_rd, mem_wr, cpu_ack}, 32'd0);

        // VRAM read: locked in DRAW, open in HBLANK
        lcd_en = 1; ppu_mode = 2'd3;
        cpu_access(0, 16'h8010, 8'h00, rd, lat);
        check("blk_vram_rd_data", {24'd0, rd}, 32'hFF);
        check("blk_vram_rd_lat", lat, 1);
        ppu_mode = 2'd0;
        cpu_access(0, 16'h8010, 8'h00, rd, lat);
        check("vram_rd_data", {24'd0, rd}, 32'h5A);
        check("vram_rd_lat", lat, 1);

        // OAM write: dropped in SCAN with LCD on, performed with LCD off
        ppu_mode = 2'd2;
        cpu_access(1, 16'hFE05, 8'hAA, rd, lat);
        check("blk_oam_wr_lat", lat, 1);
        check("blk_oam_wr_mem", {24'd0, mem_arr[16'hFE05]}, 32'hFB);
        lcd_en = 0;
        cpu_access(1, 16'hFE05, 8'hAA, rd, lat);
        check("oam_wr_mem", {24'd0, mem_arr[16'hFE05]}, 32'hAA);

        // Full DMA from C100 with PPU and CPU traffic alongside
        lcd_en = 1; ppu_mode = 2'd3;
        cpu_access(1, 16'hFF46, 8'hC1, rd, lat);
        check("ff46_lat", lat, 1);
        ppu_addr = 16'h9800; ppu_rd = 1;
        cpu_access(0, 16'hFE10, 8'h00, rd, lat);
        check("dma_oam_rd_blocked", {24'd0, rd}, 32'hFF);
        cpu_access(0, 16'hC000, 8'h00, rd, lat);
        check("dma_gap_cpu_rd", {24'd0, rd}, 32'hC0);
        repeat (40) @(negedge clk);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #2;
            if (ppu_ack) seen = 1;
            @(negedge clk);
        end
        check("ppu_ack_during_dma", {31'd0, seen}, 32'd1);
        ppu_rd = 0;
        wait_dma_idle("dma_c1_done");
        oam_compare("oam_c1_copy", 8'hC1);
        check("oam_fe00", {24'd0, mem_arr[16'hFE00]}, 32'hC1);
        check("oam_fe9f", {24'd0, mem_arr[16'hFE9F]}, 32'h5E);

        // Restart at idx 50 with source D0
        lcd_en = 0; ppu_mode = 2'd0;
        cpu_access(1, 16'hFF46, 8'hC1, rd, lat);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (mem_rd && mem_addr == 16'hC132) seen = 1;
        end
        check("reach_idx50", {31'd0, seen}, 32'd1);
        cpu_access(1, 16'hFF46, 8'hD0, rd, lat);
        wait_dma_idle("dma_d0_done");
        oam_compare("oam_d0_copy", 8'hD0);
        check("oam_fe10_d0", {24'd0, mem_arr[16'hFE10]}, 32'hC0);
        check("oam_fe32_d0", {24'd0, mem_arr[16'hFE32]}, 32'hE2);

        // Reset while the WR to FE14 is on the port
        cpu_access(1, 16'hFF46, 8'hC1, rd, lat);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (mem_wr && mem_addr == 16'hFE14) seen = 1;
        end
        check("reach_idx20", {31'd0, seen}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_async_dma_active", {31'd0, dma_active}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #2;
        check("post_rst_dma_active", {31'd0, dma_active}, 32'd0);
        check("oam_fe13_c1", {24'd0, mem_arr[16'hFE13]}, 32'hD2);
        check("oam_fe14_kept", {24'd0, mem_arr[16'hFE14]}, 32'hC4);
        check("oam_fe15_kept", {24'd0, mem_arr[16'hFE15]}, 32'hC5);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
